timer_alarm_scheduler: RTL and testbench
========================================

// Module: timer_alarm_scheduler
// PURPOSE
//  Shares the single timer instance (start / rst_capture / alarm) between NREQ requesters.
//  Each requester asks for an alarm N clocks after timer start.
//  Arbitration is round-robin; one request owns the timer at a time.
//  Block sequences rst_capture -> alarm program -> start -> wait, guards each slot with a
//  watchdog, and returns a per-requester completion pulse with a status code.
//  Sits between the requesting control blocks and the timer's control inputs.
// PARAMETERS
//  NREQ       4   number of requesters (2..8)
//  CNT_W      16  width of requested alarm time in clks; matches timer alarm_in width
//  WD_MARGIN  16  extra clks beyond requested time before watchdog declares timeout
// PORTS
//  clk              in   1           system clock
//  sreset           in   1           synchronous reset, active-high
//  req_valid        in   NREQ        per-requester request; held high until req_ready
//  req_clks         in   NREQ*CNT_W  alarm time per requester; slice i = [i*CNT_W +: CNT_W]
//  req_cancel       in   NREQ        abort the in-flight request of requester i
//  req_ready        out  NREQ        one-hot, 1-cycle accept pulse
//  done_valid       out  NREQ        one-hot, 1-cycle completion pulse
//  done_code        out  2           status, valid with done_valid: 00 ok, 01 timeout, 10 cancelled
//  busy             out  1           timer owned (state != IDLE)
//  grant_id         out  $clog2(NREQ)  index of current owner; holds last owner when idle
//  tmr_rst_capture  out  1           1-cycle pulse to timer capture reset
//  tmr_alarm_en     out  1           timer alarm enable
//  tmr_alarm_clks   out  CNT_W       timer alarm time; stable while tmr_alarm_en = 1
//  tmr_start        out  1           1-cycle start pulse to timer
//  tmr_alarm        in   1           alarm pulse from timer
// BEHAVIOUR
//  Reset
//   - All outputs are 0; grant_id is 0.
//   - State is IDLE; RR pointer is NREQ-1, so requester 0 has first priority.
//   - sreset mid-slot aborts immediately. No done_valid is issued for the aborted request.
//  FSM: IDLE -> LOAD -> START -> WAIT -> DONE -> IDLE
//   - IDLE
//     - If any req_valid is high, pick the first set bit searching from ptr+1 (wrapping).
//     - Pulse req_ready[w], latch req_clks[w] and w, set ptr = w, go to LOAD.
//   - LOAD (accept cycle T+1)
//     - tmr_rst_capture = 1, tmr_alarm_en = 1, tmr_alarm_clks = latched value.
//     - If latched value == 0: go to DONE with code 00, never pulse tmr_start.
//   - START (T+2)
//     - tmr_start = 1 for one cycle; clear the watchdog.
//   - WAIT (from T+3)
//     - Watchdog width is CNT_W+1 bits and never wraps; it increments each cycle.
//     - tmr_alarm = 1: go to DONE, code 00.
//     - Otherwise req_cancel[owner] = 1: go to DONE, code 10.
//     - Otherwise watchdog == latched + WD_MARGIN (computed at CNT_W+1 bits): go to DONE, code 01.
//     - Priority: alarm > cancel > timeout when they occur in the same cycle.
//   - DONE
//     - done_valid[owner] = 1 with done_code; tmr_alarm_en = 0; go to IDLE.
//     - A new grant is possible on the following cycle.
//  Rules
//   - tmr_alarm outside WAIT is ignored.
//   - req_cancel of a non-owner, or in any state other than WAIT, is ignored.
//   - A requester may re-request in the cycle after its done_valid.
//     - RR still serves other pending requesters first.
//   - req_valid dropped before req_ready is legal. Arbitration uses only current-cycle req_valid.
//   - tmr_alarm_en stays high from LOAD through WAIT; tmr_alarm_clks is constant over that span.
//   - At most one bit of req_ready and of done_valid is set per cycle.
// TESTING
//  1. Single request: req_valid[0], req_clks = 100; model alarm at start+100.
//     -> req_ready[0] at T, tmr_start at T+2, done_valid[0] code 00 one cycle after alarm.
//  2. Round-robin: all 4 requesters hold requests with clks = 10.
//     -> grants in order 0,1,2,3.
//     -> Then with only 1 and 3 re-requesting after owner 3: order 1,3.
//  3. Timeout: req_clks = 50, model never alarms.
//     -> done code 01 exactly 50+16 cycles after entering WAIT; tmr_alarm_en falls with done.
//  4. Cancel and collision:
//     -> Cancel at WAIT+20 gives code 10.
//     -> Alarm and cancel in the same cycle gives code 00.
//     -> Cancel from a non-owner has no effect.
//  5. Zero and maximum requests:
//     -> clks = 0: done code 00 at T+2, no tmr_start.
//     -> clks = 16'hFFFF: no overflow; timeout fires at 65535+16 if no alarm.
//  6. sreset asserted in WAIT:
//     -> next cycle all outputs are 0, no done_valid; next request from req 0 wins first.

Source files
------------

// File: rtl/timer_alarm_scheduler.sv
// timer_alarm_scheduler
// Lends a single hardware timer to NREQ requesters, one slot at a time, with
// round-robin arbitration. Each slot runs: capture reset + alarm program,
// start pulse, then a wait that ends on alarm, owner cancel or watchdog expiry.
// The owner gets a one-cycle completion pulse with a status code.
module timer_alarm_scheduler #(
    parameter int NREQ      = 4,
    parameter int CNT_W     = 16,
    parameter int WD_MARGIN = 16
) (
    input  logic                    clk,
    input  logic                    sreset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*CNT_W-1:0]   req_clks,
    input  logic [NREQ-1:0]         req_cancel,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         done_valid,
    output logic [1:0]              done_code,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    tmr_rst_capture,
    output logic                    tmr_alarm_en,
    output logic [CNT_W-1:0]        tmr_alarm_clks,
    output logic                    tmr_start,
    input  logic                    tmr_alarm
);
    localparam int ID_W = $clog2(NREQ);
    localparam int WD_W = CNT_W + 1;

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_CANCEL  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   pick_id;
    logic              pick_found;
    logic [CNT_W-1:0]  clks_lat;
    logic [WD_W-1:0]   wd;
    logic [WD_W-1:0]   wd_inc;
    logic [WD_W-1:0]   wd_lim;
    logic              timeout;
    logic [1:0]        code;
    logic [1:0]        code_n;
    int                idx;

    // Watchdog limit: requested time plus margin, one bit wider so the
    // largest request cannot overflow.
    function automatic logic [WD_W-1:0] limit_of(input logic [CNT_W-1:0] t);
        return {1'b0, t} + WD_W'(WD_MARGIN);
    endfunction

    // Round-robin search: first pending requester after the last grant, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // The watchdog counts WAIT cycles; expiry is detected on the increment
    // that reaches the limit, so WAIT lasts at most limit cycles.
    always_comb begin
        wd_inc  = wd + WD_W'(1);
        wd_lim  = limit_of(clks_lat);
        timeout = (wd_inc == wd_lim);
    end

    // Next-state logic and the completion code chosen on the way into DONE.
    always_comb begin
        state_n = state;
        code_n  = CODE_OK;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (clks_lat == '0) begin
                    state_n = S_DONE;
                    code_n  = CODE_OK;
                end else begin
                    state_n = S_START;
                end
            end
            S_START: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (tmr_alarm) begin
                    state_n = S_DONE;
                    code_n  = CODE_OK;
                end else if (req_cancel[owner]) begin
                    state_n = S_DONE;
                    code_n  = CODE_CANCEL;
                end else if (timeout) begin
                    state_n = S_DONE;
                    code_n  = CODE_TIMEOUT;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Control state: FSM, arbitration pointer, owner, status code, watchdog.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state <= S_IDLE;
            ptr   <= ID_W'(NREQ - 1);
            owner <= '0;
            code  <= CODE_OK;
            wd    <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && pick_found) begin
                ptr   <= pick_id;
                owner <= pick_id;
            end
            if (state != S_DONE && state_n == S_DONE) begin
                code <= code_n;
            end
            if (state == S_START) begin
                wd <= '0;
            end else if (state == S_WAIT) begin
                wd <= wd_inc;
            end
        end
    end

    // Requested alarm time of the winner, captured at accept.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && pick_found) begin
            clks_lat <= req_clks[int'(pick_id)*CNT_W +: CNT_W];
        end
    end

    // Outputs decoded from state; data outputs are forced to 0 when not valid.
    always_comb begin
        req_ready       = '0;
        done_valid      = '0;
        done_code       = CODE_OK;
        busy            = (state != S_IDLE);
        grant_id        = owner;
        tmr_rst_capture = (state == S_LOAD);
        tmr_start       = (state == S_START);
        tmr_alarm_en    = (state == S_LOAD) || (state == S_START) || (state == S_WAIT);
        tmr_alarm_clks  = '0;
        if (state == S_IDLE && pick_found && !sreset) begin
            req_ready[pick_id] = 1'b1;
        end
        if (state == S_DONE) begin
            done_valid[owner] = 1'b1;
            done_code         = code;
        end
        if (tmr_alarm_en) begin
            tmr_alarm_clks = clks_lat;
        end
    end

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Bench for timer_alarm_scheduler: directed slots plus randomized slots, each
// predicted by a slot-level model (arbitration by circular distance, slot
// timeline by arithmetic on the requested time and planned alarm/cancel).
module tb_timer_alarm_scheduler;
    localparam int NREQ      = 4;
    localparam int CNT_W     = 16;
    localparam int WD_MARGIN = 16;

    logic                  clk = 1'b0;
    logic                  sreset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*CNT_W-1:0] req_clks;
    logic [NREQ-1:0]       req_cancel;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       done_valid;
    logic [1:0]            done_code;
    logic                  busy;
    logic [1:0]            grant_id;
    logic                  tmr_rst_capture;
    logic                  tmr_alarm_en;
    logic [CNT_W-1:0]      tmr_alarm_clks;
    logic                  tmr_start;
    logic                  tmr_alarm;

    int n_cmp = 0;
    int n_err = 0;
    int m_ptr;
    logic [CNT_W-1:0] rq_clks [NREQ];

    timer_alarm_scheduler #(
        .NREQ(NREQ), .CNT_W(CNT_W), .WD_MARGIN(WD_MARGIN)
    ) dut (
        .clk(clk), .sreset(sreset),
        .req_valid(req_valid), .req_clks(req_clks), .req_cancel(req_cancel),
        .req_ready(req_ready), .done_valid(done_valid), .done_code(done_code),
        .busy(busy), .grant_id(grant_id),
        .tmr_rst_capture(tmr_rst_capture), .tmr_alarm_en(tmr_alarm_en),
        .tmr_alarm_clks(tmr_alarm_clks), .tmr_start(tmr_start),
        .tmr_alarm(tmr_alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Winner = pending requester at the smallest circular distance after ptr.
    function automatic int model_pick(input logic [NREQ-1:0] mask, input int ptr);
        int best;
        int bd;
        best = -1;
        bd   = NREQ + 1;
        for (int j = 0; j < NREQ; j++) begin
            if (mask[j]) begin
                int d;
                d = (j - ptr - 1 + 2 * NREQ) % NREQ;
                if (d < bd) begin
                    bd   = d;
                    best = j;
                end
            end
        end
        return best;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_done"}, done_valid, 0);
        chk({tag, "_code"}, done_code, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_cap"}, tmr_rst_capture, 0);
        chk({tag, "_en"}, tmr_alarm_en, 0);
        chk({tag, "_aclk"}, tmr_alarm_clks, 0);
        chk({tag, "_start"}, tmr_start, 0);
    endtask

    task automatic do_reset();
        sreset     = 1'b1;
        req_valid  = '0;
        req_cancel = '0;
        tmr_alarm  = 1'b0;
        repeat (2) @(negedge clk);
        sreset = 1'b0;
        m_ptr  = NREQ - 1;
        #1;
        check_quiet("reset");
    endtask

    // One slot, entered at an IDLE-cycle negedge. Offsets are counted in
    // cycles from tmr_start (0 = not planned). Returns at the next IDLE negedge.
    task automatic run_slot(input logic [NREQ-1:0] mask, input int alarm_off,
                            input int cancel_off, input bit noise,
                            output int winner, output logic [1:0] code_obs,
                            output int off_obs);
        int exp_w, clk_w, lim, best, exp_off, budget, start_k, done_k;
        logic [1:0] exp_code;
        logic en_prev;
        logic stable_bad;
        exp_w = model_pick(mask, m_ptr);
        for (int i = 0; i < NREQ; i++) req_clks[i*CNT_W +: CNT_W] = rq_clks[i];
        req_valid  = mask;
        req_cancel = '0;
        tmr_alarm  = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("ready_onehot", req_ready, 32'(1) << exp_w);
        winner = -1;
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) winner = j;
        clk_w = int'(rq_clks[exp_w]);
        if (clk_w == 0) begin
            exp_off  = 2;
            exp_code = 2'b00;
            budget   = 10;
        end else begin
            lim      = clk_w + WD_MARGIN;
            best     = lim + 2;
            exp_code = 2'b01;
            if (cancel_off > 0 && cancel_off + 2 <= best) begin
                best     = cancel_off + 2;
                exp_code = 2'b10;
            end
            if (alarm_off > 0 && alarm_off + 2 <= best) begin
                best     = alarm_off + 2;
                exp_code = 2'b00;
            end
            exp_off = best + 1;
            budget  = lim + 12;
        end
        m_ptr      = exp_w;
        start_k    = -1;
        done_k     = -1;
        en_prev    = 1'b0;
        stable_bad = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            req_valid  = '0;
            tmr_alarm  = (alarm_off > 0 && k == alarm_off + 2) || (noise && k <= 2);
            req_cancel = '0;
            if (noise) req_cancel[(exp_w + 1) % NREQ] = 1'b1;
            if ((cancel_off > 0 && k == cancel_off + 2) || (noise && k <= 2))
                req_cancel[exp_w] = 1'b1;
            #1;
            if (k == 1) begin
                chk("load_cap", tmr_rst_capture, 1);
                chk("load_en", tmr_alarm_en, 1);
                chk("load_aclk", tmr_alarm_clks, clk_w);
                chk("load_gid", grant_id, exp_w);
                chk("load_busy", busy, 1);
            end
            if (tmr_start && start_k < 0) start_k = k;
            if (done_valid != 0) begin
                done_k = k;
                break;
            end
            if (tmr_alarm_en && tmr_alarm_clks !== CNT_W'(clk_w)) stable_bad = 1'b1;
            en_prev = tmr_alarm_en;
        end
        code_obs = done_code;
        off_obs  = done_k;
        chk("done_seen", done_k > 0, 1);
        chk("done_offset", done_k, exp_off);
        chk("done_onehot", done_valid, 32'(1) << exp_w);
        chk("done_code", done_code, exp_code);
        chk("en_at_done", tmr_alarm_en, 0);
        chk("en_before_done", en_prev, 1);
        chk("start_offset", start_k, (clk_w == 0) ? -1 : 2);
        chk("aclk_stable", stable_bad, 0);
        tmr_alarm  = 1'b0;
        req_cancel = '0;
        @(negedge clk);
    endtask

    initial begin
        int w;
        int off;
        logic [1:0] c;
        logic [NREQ-1:0] rmask;
        int ra, rc;
        for (int i = 0; i < NREQ; i++) rq_clks[i] = '0;
        req_clks = '0;
        do_reset();

        // Single request, alarm 100 clocks after start.
        rq_clks[0] = 16'd100;
        run_slot(4'b0001, 100, 0, 1'b0, w, c, off);
        chk("t1_winner", w, 0);
        chk("t1_code", c, 2'b00);
        chk("t1_off", off, 103);

        // Round-robin from reset, then partial re-request.
        do_reset();
        for (int i = 0; i < NREQ; i++) rq_clks[i] = 16'd10;
        run_slot(4'b1111, 10, 0, 1'b0, w, c, off);
        chk("rr_0", w, 0);
        run_slot(4'b1110, 10, 0, 1'b0, w, c, off);
        chk("rr_1", w, 1);
        run_slot(4'b1100, 10, 0, 1'b0, w, c, off);
        chk("rr_2", w, 2);
        run_slot(4'b1000, 10, 0, 1'b0, w, c, off);
        chk("rr_3", w, 3);
        run_slot(4'b1010, 10, 0, 1'b0, w, c, off);
        chk("rr_b1", w, 1);
        run_slot(4'b1000, 10, 0, 1'b0, w, c, off);
        chk("rr_b3", w, 3);

        // Timeout: 50 + 16 WAIT cycles, WAIT entered at offset 3.
        rq_clks[0] = 16'd50;
        run_slot(4'b0001, 0, 0, 1'b0, w, c, off);
        chk("t3_code", c, 2'b01);
        chk("t3_off", off, 3 + 66);

        // Cancel at WAIT+20, alarm/cancel collision, non-owner cancel noise.
        rq_clks[1] = 16'd40;
        run_slot(4'b0010, 0, 21, 1'b0, w, c, off);
        chk("t4_cancel_code", c, 2'b10);
        run_slot(4'b0010, 15, 15, 1'b0, w, c, off);
        chk("t4_collide_code", c, 2'b00);
        run_slot(4'b0010, 30, 0, 1'b1, w, c, off);
        chk("t4_noise_code", c, 2'b00);

        // Zero and maximum request.
        rq_clks[2] = 16'd0;
        run_slot(4'b0100, 0, 0, 1'b0, w, c, off);
        chk("t5_zero_off", off, 2);
        rq_clks[3] = 16'hFFFF;
        run_slot(4'b1000, 0, 0, 1'b0, w, c, off);
        chk("t5_max_code", c, 2'b01);
        chk("t5_max_off", off, 3 + 65535 + 16);

        // Randomized slots.
        for (int n = 0; n < 40; n++) begin
            rmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
                rq_clks[i] = ($urandom_range(0, 4) == 0) ? '0 : CNT_W'($urandom_range(1, 30));
            ra = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 55));
            rc = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 55));
            if ($urandom_range(0, 5) == 0) rc = ra;
            run_slot(rmask, ra, rc, 1'($urandom_range(0, 1)), w, c, off);
        end

        // sreset in WAIT: quiet outputs, no completion, priority back to 0.
        rq_clks[2] = 16'd40;
        for (int i = 0; i < NREQ; i++) req_clks[i*CNT_W +: CNT_W] = rq_clks[i];
        req_valid = 4'b0100;
        #1;
        chk("t6_ready", req_ready, 4'b0100);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            req_valid = '0;
            if (k == 9) sreset = 1'b1;
        end
        #1;
        chk("t6_busy_wait", busy, 1);
        @(negedge clk);
        sreset = 1'b0;
        #1;
        check_quiet("t6");
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("t6_no_done", done_valid, 0);
        end
        m_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) rq_clks[i] = 16'd5;
        run_slot(4'b1111, 5, 0, 1'b0, w, c, off);
        chk("t6_winner", w, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
